mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the instruction-fetch port (IF) and the load/store data port (DM) of the pipelined core.
- Grants one transaction at a time and counts out the memory latency.
- Routes the read response back to the owning port.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; strobe width is DATA_W/8
MEM_LAT, 2, cycles from issue (mem_en) to valid mem_rdata; legal range 1..15
STARVE_MAX, 4, consecutive DM grants with if_req pending before IF is forced to win; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid (one-cycle pulse)
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request, held until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_wstrb  in  DATA_W/8  store byte enables
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  load data valid, or store completion ack (one-cycle pulse)
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access issue strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables (all zero on reads)
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE, latency counter = 0, starve counter = 0, owner = IF.
- Outputs during reset: if_gnt, dm_gnt, mem_en, mem_we, if_rvalid and dm_rvalid are 0. mem_wstrb is 0.
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: a transaction is outstanding.
- Grant eligibility: a grant may be issued in IDLE, or in BUSY during the cycle the latency counter reaches MEM_LAT (the response cycle). This gives back-to-back throughput of one access per MEM_LAT cycles.
- Grants are combinational from req and state. At most one of if_gnt and dm_gnt is high per cycle.
- Arbitration, when eligible:
  - Both requesting and starve < STARVE_MAX: DM wins.
  - Both requesting and starve == STARVE_MAX: IF wins.
  - Only one requesting: that port wins.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each dm_gnt while if_req = 1.
  - Clears on if_gnt, and in any cycle with if_req = 0.
- Issue cycle T: mem_en = 1. The winning port's address, we, wdata and wstrb drive the mem_* outputs combinationally. IF issues force mem_we = 0 and mem_wstrb = 0. Owner is registered and the latency counter loads 1; state moves to BUSY.
- BUSY: latency counter increments each cycle.
  - At counter == MEM_LAT (cycle T+MEM_LAT), the owner's rvalid pulses for exactly one cycle and its rdata = mem_rdata.
  - The non-owner rvalid stays 0, and its rdata holds its last value.
  - Next state: BUSY with the counter reloaded to 1 if a new grant issues in that cycle, else IDLE.
- Stores: dm_rvalid still pulses at T+MEM_LAT as a completion ack. dm_rdata is don't-care.
- MEM_LAT = 1: the response cycle is T+1. Continuous requests issue every cycle.
- Requesters may drop req before their grant; no transaction results. Address and data are sampled only in the grant cycle.
- Reset asserted mid-transaction: the outstanding response is discarded. No rvalid appears after rst_n deasserts, and the FSM restarts in IDLE.
- Exactly one rvalid pulse per grant, in grant order.

Test Plan:
- Lone fetch, MEM_LAT=2: if_req at cycle 0 with if_addr=0x100, memory returns 0x00A00093 -> if_gnt and mem_en at cycle 0, if_rvalid=1 with if_rdata=0x00A00093 at cycle 2 only. No dm_* activity.
- Simultaneous if_req and dm_req (load, dm_addr=0x2000) -> dm_gnt at cycle 0 and if_gnt at cycle 2. dm_rvalid at 2, if_rvalid at 4. Grants are never concurrent.
- Store dm_we=1, dm_wstrb=4'b0011, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wstrb=0011 at the issue cycle, dm_rvalid ack at issue+MEM_LAT. if_rvalid stays 0.
- Starvation, STARVE_MAX=4, dm_req and if_req held high continuously -> 4 DM grants, then 1 IF grant, then DM again. The starve counter is 0 after the IF grant.
- Back-to-back with MEM_LAT=1 and dm_req held for 5 cycles -> mem_en high for 5 consecutive cycles, dm_rvalid pulses on cycles 1..5.
- Reset mid-transaction: issue a load, drop rst_n one cycle later for 2 cycles -> no dm_rvalid ever appears. After release, the next request is granted from IDLE with normal latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch (IF)
// and load/store (DM); DM has priority, with a starvation limit that protects fetch.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                dbg_state,
    output logic [3:0]          dbg_starve
);

    // Handshake: a requester holds req (and its address/data) until it sees gnt;
    // the transfer happens in the cycle where req and gnt are both high. rvalid is
    // an unconditional one-cycle pulse with no back-pressure.

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t            state;
    logic [3:0]        lat_cnt;
    logic [3:0]        starve;
    logic              owner_dm;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic resp;
    logic eligible;
    logic dm_win;

    // The response cycle doubles as the next grant slot, giving one access per MEM_LAT cycles.
    assign resp     = (state == BUSY) && (lat_cnt == LAT);
    assign eligible = rst_n && ((state == IDLE) || resp);
    assign dm_win   = dm_req && (!if_req || (starve < SMAX));

    assign if_gnt = eligible && if_req && !dm_win;
    assign dm_gnt = eligible && dm_win;

    assign mem_en    = if_gnt || dm_gnt;
    assign mem_we    = dm_gnt && dm_we;
    assign mem_addr  = dm_gnt ? dm_addr : if_addr;
    assign mem_wdata = dm_gnt ? dm_wdata : '0;
    assign mem_wstrb = mem_we ? dm_wstrb : '0;

    assign if_rvalid = resp && !owner_dm;
    assign dm_rvalid = resp && owner_dm;
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;

    assign dbg_state  = state;
    assign dbg_starve = starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= 4'd0;
            starve     <= 4'd0;
            owner_dm   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (mem_en) begin
                state    <= BUSY;
                lat_cnt  <= 4'd1;
                owner_dm <= dm_gnt;
            end else if (resp) begin
                state   <= IDLE;
                lat_cnt <= 4'd0;
            end else if (state == BUSY) begin
                lat_cnt <= lat_cnt + 4'd1;
            end

            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (dm_rvalid) dm_rdata_q <= mem_rdata;

            // Counts DM wins only while fetch is actually waiting.
            if (!if_req || if_gnt) begin
                starve <= 4'd0;
            end else if (dm_gnt && (starve < SMAX)) begin
                starve <= starve + 4'd1;
            end
        end
    end

endmodule
